sipo_word_receiver: RTL and testbench

- Serial-in/parallel-out receiver for the 12-bit LSB-first word stream that the spectrogram datapath's PISO serializer emits.
- Rebuilds each word from a framed bit stream and presents it on a parallel bus with a valid/ready handshake.
- Flags overrun and frame aborts.
- Sits on the consuming side of the serial link, for example the readout path or a loopback checker.

---
 rtl/spectro_serial_pkg.sv | 23 ++
 rtl/sipo_shift_core.sv | 69 ++++++
 rtl/sipo_word_receiver.sv | 135 +++++++++++++
 tb/tb_sipo_word_receiver.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/spectro_serial_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spectro_serial_pkg                                                         |
// | Shared word width, receiver state encoding and parity helper.              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package spectro_serial_pkg;

    localparam int WORD_W = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } sipo_state_t;

    // Odd number of ones in the (zero-extended) data word.
    function automatic logic odd_ones(input logic [63:0] bits);
        return ^bits;
    endfunction

endpackage : spectro_serial_pkg
`default_nettype wire

// File: rtl/sipo_shift_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sipo_shift_core                                                            |
// | Shift register, bit counter and completion/abort detect for the receiver.  |
// | Build option: SIPO_PARITY_CHECK_EN adds a trailing parity-bit phase.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module sipo_shift_core #(
    parameter int WIDTH = 12,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    input  logic             in_frame,
`ifdef SIPO_PARITY_CHECK_EN
    input  logic             in_parity,
    output logic             data_full,
`endif
    output logic [WIDTH-1:0] word,
    output logic             done,
    output logic             abort
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_count;

    logic             w_start;
    logic             w_data_bit;
    logic             w_last_data;
    logic [WIDTH-1:0] w_shifted;

    // Bits enter at the MSB, so after WIDTH shifts bit 0 has reached the LSB
    // and any leftover of an aborted word has been pushed out.
    assign w_start     = bit_valid && frame_start;
    assign w_shifted   = {serial_in, r_shreg[WIDTH-1:1]};
    assign w_last_data = w_data_bit && (r_count == c_last);
    assign abort       = w_start && in_frame;

`ifdef SIPO_PARITY_CHECK_EN
    assign w_data_bit = bit_valid && !frame_start && in_frame && !in_parity;
    assign data_full  = w_last_data;
    assign done       = bit_valid && !frame_start && in_parity;
    assign word       = r_shreg;
`else
    assign w_data_bit = bit_valid && !frame_start && in_frame;
    assign done       = w_last_data;
    assign word       = w_shifted;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
            r_count <= '0;
        end else if (w_start) begin
            r_shreg <= w_shifted;
            r_count <= CNT_W'(1);
        end else if (w_data_bit) begin
            r_shreg <= w_shifted;
            r_count <= w_last_data ? '0 : r_count + 1'b1;
        end
    end

endmodule : sipo_shift_core
`default_nettype wire

// File: rtl/sipo_word_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sipo_word_receiver                                                         |
// | LSB-first framed serial-to-parallel receiver with valid/ready output,      |
// | sticky overrun and frame-abort pulse.                                      |
// | Build option: SIPO_PARITY_CHECK_EN enables the even-parity bit check.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module sipo_word_receiver
    import spectro_serial_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             clr_overrun,
    output logic             frame_abort,
    output logic             parity_err
);

    sipo_state_t      r_state;
    logic [WIDTH-1:0] r_parallel;
    logic             r_out_valid;
    logic             r_overrun;
    logic             r_frame_abort;
    logic             r_parity_err;

    logic [WIDTH-1:0] w_word;
    logic             w_done;
    logic             w_abort;
    logic             w_start;
    logic             w_accept;
    logic             w_load;
    logic             w_par_err;
    logic             w_in_frame;
`ifdef SIPO_PARITY_CHECK_EN
    logic             w_in_parity;
    logic             w_data_full;
`endif

    assign w_start    = bit_valid && frame_start;
    assign w_in_frame = (r_state != IDLE);
    assign w_accept   = r_out_valid && out_ready;
    // A completed word is taken if the holding register is empty or being
    // drained on this same edge; otherwise it is dropped.
    assign w_load     = w_done && (!r_out_valid || out_ready);

`ifdef SIPO_PARITY_CHECK_EN
    assign w_in_parity = (r_state == PARITY);
    assign w_par_err   = odd_ones(64'(w_word)) ^ serial_in;
`else
    assign w_par_err   = 1'b0;
`endif

    sipo_shift_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .serial_in   (serial_in),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .in_frame    (w_in_frame),
`ifdef SIPO_PARITY_CHECK_EN
        .in_parity   (w_in_parity),
        .data_full   (w_data_full),
`endif
        .word        (w_word),
        .done        (w_done),
        .abort       (w_abort)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_parallel    <= '0;
            r_out_valid   <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_abort <= 1'b0;
            r_parity_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) r_state <= SHIFT;
                end
                SHIFT: begin
                    if (w_start)          r_state <= SHIFT;
`ifdef SIPO_PARITY_CHECK_EN
                    else if (w_data_full) r_state <= PARITY;
`else
                    else if (w_done)      r_state <= IDLE;
`endif
                end
`ifdef SIPO_PARITY_CHECK_EN
                PARITY: begin
                    if (w_start)     r_state <= SHIFT;
                    else if (w_done) r_state <= IDLE;
                end
`endif
                default: r_state <= IDLE;
            endcase

            r_frame_abort <= w_abort;

            if (w_load) begin
                r_parallel   <= w_word;
                r_parity_err <= w_par_err;
                r_out_valid  <= 1'b1;
            end else if (w_accept) begin
                r_out_valid  <= 1'b0;
            end

            // Set wins over a same-cycle clear so a drop is never lost.
            if (w_done && !w_load) r_overrun <= 1'b1;
            else if (clr_overrun)  r_overrun <= 1'b0;
        end
    end

    assign parallel_out = r_parallel;
    assign out_valid    = r_out_valid;
    assign overrun      = r_overrun;
    assign frame_abort  = r_frame_abort;
    assign parity_err   = r_parity_err;

endmodule : sipo_word_receiver
`default_nettype wire

// File: tb/tb_sipo_word_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sipo_word_receiver                                                      |
// | Directed bench for sipo_word_receiver; honours SIPO_PARITY_CHECK_EN.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_sipo_word_receiver;

    localparam int WIDTH = 12;
    localparam int NV    = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             serial_in;
    logic             bit_valid;
    logic             frame_start;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic             clr_overrun;
    logic             frame_abort;
    logic             parity_err;

    int n_cmp = 0;
    int n_err = 0;
    int early_hits = 0;
    int abort_seen = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               gap;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs [NV];

    sipo_word_receiver #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .serial_in    (serial_in),
        .bit_valid    (bit_valid),
        .frame_start  (frame_start),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun),
        .clr_overrun  (clr_overrun),
        .frame_abort  (frame_abort),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_abort) abort_seen = abort_seen + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input logic fs);
        @(negedge clk);
        if (out_valid) early_hits++;
        bit_valid   = 1'b1;
        serial_in   = b;
        frame_start = fs;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            if (out_valid) early_hits++;
            bit_valid   = 1'b0;
            frame_start = 1'b0;
        end
    endtask

    // Leaves the last bit driven; clr_last raises clr_overrun with that bit.
    task automatic send_word(input logic [WIDTH-1:0] data, input int gap,
                             input logic pbit, input logic clr_last);
        for (int i = 0; i < WIDTH; i++) begin
            drive_bit(data[i], (i == 0));
            if (i != WIDTH - 1) idle_cycles(gap);
        end
`ifdef SIPO_PARITY_CHECK_EN
        idle_cycles(gap);
        drive_bit(pbit, 1'b0);
`endif
        clr_overrun = clr_last;
    endtask

    task automatic end_drive();
        @(negedge clk);
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        clr_overrun = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_perr;

        vecs[0] = '{data: 12'hA5C, gap: 0, exp: 12'hA5C};
        vecs[1] = '{data: 12'h3F1, gap: 1, exp: 12'h3F1};
        vecs[2] = '{data: 12'h000, gap: 0, exp: 12'h000};
        vecs[3] = '{data: 12'hFFF, gap: 2, exp: 12'hFFF};
        vecs[4] = '{data: 12'h801, gap: 0, exp: 12'h801};
        vecs[5] = '{data: 12'h2B6, gap: 3, exp: 12'h2B6};

        rst_n = 1'b0; serial_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
        out_ready = 1'b1; clr_overrun = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_parallel_out", int'(parallel_out), 0);
        check("rst_out_valid",    int'(out_valid), 0);
        check("rst_overrun",      int'(overrun), 0);
        check("rst_frame_abort",  int'(frame_abort), 0);
        check("rst_parity_err",   int'(parity_err), 0);
        rst_n = 1'b1;

        // Single words with out_ready held high
        for (int v = 0; v < NV; v++) begin
            early_hits = 0;
            send_word(vecs[v].data, vecs[v].gap, ^vecs[v].data, 1'b0);
            end_drive();
            check("early_valid", early_hits, 0);
            check("valid_rise",  int'(out_valid), 1);
            check("word",        int'(parallel_out), int'(vecs[v].exp));
            check("parity_ok",   int'(parity_err), 0);
            @(negedge clk);
            check("valid_fall",  int'(out_valid), 0);
        end

        // Back-to-back words with out_ready low: second word dropped
        out_ready = 1'b0;
        send_word(12'h001, 0, 1'b1, 1'b0);
        send_word(12'hFFF, 0, 1'b0, 1'b0);
        end_drive();
        check("ovr_valid", int'(out_valid), 1);
        check("ovr_word",  int'(parallel_out), 12'h001);
        check("ovr_set",   int'(overrun), 1);
        @(negedge clk); clr_overrun = 1'b1;
        @(negedge clk); clr_overrun = 1'b0;
        check("ovr_clear",      int'(overrun), 0);
        check("ovr_word_kept",  int'(parallel_out), 12'h001);
        check("ovr_valid_kept", int'(out_valid), 1);

        // Drop on the same edge as clr_overrun: overrun must stay set
        send_word(12'h0AA, 0, 1'b0, 1'b1);
        end_drive();
        check("ovr_set_wins",  int'(overrun), 1);
        check("ovr_word_kept2", int'(parallel_out), 12'h001);
        out_ready = 1'b1; clr_overrun = 1'b1;
        @(negedge clk); clr_overrun = 1'b0;
        check("drain_valid",   int'(out_valid), 0);
        check("drain_overrun", int'(overrun), 0);

        // Partial word aborted by a new frame_start
        abort_seen = 0;
        for (int i = 0; i < 5; i++) drive_bit(1'b1, (i == 0));
        send_word(12'h800, 0, 1'b1, 1'b0);
        end_drive();
        check("abort_word",  int'(parallel_out), 12'h800);
        check("abort_valid", int'(out_valid), 1);
        idle_cycles(2);
        check("abort_pulses", abort_seen, 1);
        check("abort_low",    int'(frame_abort), 0);

        // Reset in the middle of a word
        for (int i = 0; i < 7; i++) drive_bit(i[0], (i == 0));
        @(negedge clk);
        rst_n = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
        #1;
        check("mid_rst_parallel_out", int'(parallel_out), 0);
        check("mid_rst_out_valid",    int'(out_valid), 0);
        check("mid_rst_overrun",      int'(overrun), 0);
        check("mid_rst_frame_abort",  int'(frame_abort), 0);
        check("mid_rst_parity_err",   int'(parity_err), 0);
        @(negedge clk); rst_n = 1'b1;
        abort_seen = 0;
        send_word(12'h555, 0, 1'b0, 1'b0);
        end_drive();
        check("post_rst_word",  int'(parallel_out), 12'h555);
        check("post_rst_valid", int'(out_valid), 1);
        idle_cycles(2);
        check("post_rst_no_abort", abort_seen, 0);

        // Parity bit handling: 0x007 has three ones
        send_word(12'h007, 0, 1'b1, 1'b0);
        end_drive();
        check("par_good_word", int'(parallel_out), 12'h007);
        check("par_good_err",  int'(parity_err), 0);
        send_word(12'h007, 0, 1'b0, 1'b0);
        end_drive();
`ifdef SIPO_PARITY_CHECK_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        check("par_bad_word", int'(parallel_out), 12'h007);
        check("par_bad_err",  int'(parity_err), int'(exp_perr));
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sipo_word_receiver
`default_nettype wire
